// File: rtl/controle_entrada_saida_if.sv
// Bundle between the control unit/datapath, the board I/O and controle_entrada_saida.
// The master side drives the instruction flags and the raw board inputs.
interface controle_entrada_saida_if #(
    parameter int unsigned LARGURA_CHAVES = 16
);
    logic                      In;
    logic                      Out;
    logic                      Break;
    logic [31:0]               DadoSaida;
    logic [LARGURA_CHAVES-1:0] Chaves;
    logic                      Confirma;
    logic                      Pausa;
    logic                      EscreveIn;
    logic [31:0]               DadoEntrada;
    logic [31:0]               Display;
    logic                      DisplayValido;
    logic                      Parado;

    modport master (
        output In, Out, Break, DadoSaida, Chaves, Confirma,
        input  Pausa, EscreveIn, DadoEntrada, Display, DisplayValido, Parado
    );

    modport slave (
        input  In, Out, Break, DadoSaida, Chaves, Confirma,
        output Pausa, EscreveIn, DadoEntrada, Display, DisplayValido, Parado
    );
endinterface

// File: rtl/controle_entrada_saida.sv
// I/O responder for In/Out/Break: stalls for operator input, latches the display, halts on Break.
// Optional Confirma debounce filter is compiled in with CONTROLE_ES_DEBOUNCE_EN.
module controle_entrada_saida #(
    parameter int unsigned LARGURA_CHAVES  = 16,
    parameter logic [15:0] CICLOS_DEBOUNCE = 16'd50000
) (
    input logic                      clock,
    input logic                      reset,
    controle_entrada_saida_if.slave  es
);

    if (LARGURA_CHAVES == 0 || LARGURA_CHAVES > 32 || CICLOS_DEBOUNCE == 16'd0) begin : g_param_invalido
        $error("controle_entrada_saida: invalid LARGURA_CHAVES or CICLOS_DEBOUNCE");
    end

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_ENTRADA,
        ENTREGA,
        PARADO,
        RETOMA
    } estado_t;

    estado_t estado;

    logic sinc1;
    logic sinc2;
    logic filtrado;
    logic filtrado_ant;
    logic conf_pulso;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1        <= 1'b0;
            sinc2        <= 1'b0;
            filtrado_ant <= 1'b0;
        end else begin
            sinc1        <= es.Confirma;
            sinc2        <= sinc1;
            filtrado_ant <= filtrado;
        end
    end

`ifdef CONTROLE_ES_DEBOUNCE_EN
    logic [15:0] contador;

    // Level flips only after CICLOS_DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filtrado <= 1'b0;
            contador <= '0;
        end else if (sinc2 == filtrado) begin
            contador <= '0;
        end else if (contador == CICLOS_DEBOUNCE - 16'd1) begin
            filtrado <= sinc2;
            contador <= '0;
        end else begin
            contador <= contador + 16'd1;
        end
    end
`else
    assign filtrado = sinc2;
`endif

    assign conf_pulso = filtrado & ~filtrado_ant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= OCIOSO;
            es.EscreveIn     <= 1'b0;
            es.DadoEntrada   <= '0;
            es.Display       <= '0;
            es.DisplayValido <= 1'b0;
            es.Parado        <= 1'b0;
        end else begin
            es.EscreveIn <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (es.Break) begin
                        estado    <= PARADO;
                        es.Parado <= 1'b1;
                    end else if (es.In) begin
                        estado <= ESPERA_ENTRADA;
                    end else if (es.Out) begin
                        es.Display       <= es.DadoSaida;
                        es.DisplayValido <= 1'b1;
                    end
                end
                ESPERA_ENTRADA: begin
                    if (conf_pulso) begin
                        es.DadoEntrada <= 32'(es.Chaves);
                        es.EscreveIn   <= 1'b1;
                        estado         <= ENTREGA;
                    end
                end
                ENTREGA: estado <= OCIOSO;
                PARADO: begin
                    if (conf_pulso) begin
                        es.Parado <= 1'b0;
                        estado    <= RETOMA;
                    end
                end
                RETOMA:  estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    // Stall is decoded combinationally so the PC holds in the same cycle In/Break appears.
    always_comb begin
        es.Pausa = 1'b0;
        unique case (estado)
            OCIOSO:         es.Pausa = es.In | es.Break;
            ESPERA_ENTRADA: es.Pausa = 1'b1;
            PARADO:         es.Pausa = 1'b1;
            default:        es.Pausa = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_controle_entrada_saida.sv
// Randomized transaction-level bench for controle_entrada_saida.
// Define CONTROLE_ES_DEBOUNCE_EN to also exercise the debounce filter (CICLOS_DEBOUNCE=4).
module tb_controle_entrada_saida;

`ifdef CONTROLE_ES_DEBOUNCE_EN
    localparam int unsigned EXTRA = 4;
`else
    localparam int unsigned EXTRA = 0;
`endif
    localparam int unsigned BAIXO_MIN = EXTRA + 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    controle_entrada_saida_if #(.LARGURA_CHAVES(16)) bus ();

    controle_entrada_saida #(
        .LARGURA_CHAVES (16),
        .CICLOS_DEBOUNCE(16'd4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .es   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Architectural expectations, updated per transaction
    logic [31:0] m_display;
    logic [31:0] m_dado;
    logic        m_valido;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic borda();
        @(posedge clock);
        #1;
    endtask

    task automatic confere(input string tag, input logic pausa, input logic escreve, input logic parado);
        @(negedge clock);
        verifica({tag, "_pausa"},   32'(bus.Pausa),         32'(pausa));
        verifica({tag, "_escreve"}, 32'(bus.EscreveIn),     32'(escreve));
        verifica({tag, "_parado"},  32'(bus.Parado),        32'(parado));
        verifica({tag, "_display"}, bus.Display,            m_display);
        verifica({tag, "_valido"},  32'(bus.DisplayValido), 32'(m_valido));
        verifica({tag, "_dado"},    bus.DadoEntrada,        m_dado);
    endtask

    task automatic solta_confirma(input string tag);
        bus.Confirma = 1'b0;
        repeat (BAIXO_MIN) begin
            confere(tag, 1'b0, 1'b0, 1'b0);
            borda();
        end
    endtask

    // Fresh button press while stalled; the event is due 3+EXTRA cycles after the rise.
    task automatic sobe_confirma(input string tag, input logic parado);
        if (bus.Confirma) begin
            bus.Confirma = 1'b0;
            repeat (BAIXO_MIN) begin
                confere({tag, "_baixo"}, 1'b1, 1'b0, parado);
                borda();
            end
        end
        bus.Confirma = 1'b1;
        repeat (3 + EXTRA) begin
            confere({tag, "_sobe"}, 1'b1, 1'b0, parado);
            borda();
        end
    endtask

    task automatic op_out(input logic [31:0] v);
        bus.Out = 1'b1;
        bus.DadoSaida = v;
        confere("out", 1'b0, 1'b0, 1'b0);
        borda();
        bus.Out = 1'b0;
        bus.DadoSaida = $urandom;
        m_display = v;
        m_valido = 1'b1;
        confere("out_pos", 1'b0, 1'b0, 1'b0);
        borda();
    endtask

    task automatic op_in(input logic [15:0] ch, input int unsigned atraso, input logic com_out, input logic solta);
        bus.In = 1'b1;
        bus.Chaves = 16'($urandom);
        if (com_out) begin
            bus.Out = 1'b1;
            bus.DadoSaida = $urandom;
        end
        confere("in_decod", 1'b1, 1'b0, 1'b0);
        borda();
        repeat (atraso) begin
            confere("in_espera", 1'b1, 1'b0, 1'b0);
            borda();
        end
        bus.Chaves = ch;
        sobe_confirma("in", 1'b0);
        m_dado = {16'h0000, ch};
        confere("in_entrega", 1'b0, 1'b1, 1'b0);
        borda();
        bus.In = 1'b0;
        bus.Out = 1'b0;
        bus.Chaves = 16'($urandom);
        confere("in_fim", 1'b0, 1'b0, 1'b0);
        borda();
        if (solta) solta_confirma("in_solta");
    endtask

    task automatic op_break(input int unsigned atraso, input logic lixo, input logic solta);
        bus.Break = 1'b1;
        if (lixo) begin
            bus.In = 1'($urandom_range(0, 1));
            bus.Out = 1'b1;
            bus.DadoSaida = $urandom;
        end
        confere("brk_decod", 1'b1, 1'b0, 1'b0);
        borda();
        repeat (atraso) begin
            confere("brk_parado", 1'b1, 1'b0, 1'b1);
            borda();
        end
        sobe_confirma("brk", 1'b1);
        confere("brk_retoma", 1'b0, 1'b0, 1'b0);
        borda();
        bus.Break = 1'b0;
        bus.In = 1'b0;
        bus.Out = 1'b0;
        confere("brk_fim", 1'b0, 1'b0, 1'b0);
        borda();
        if (solta) solta_confirma("brk_solta");
    endtask

    task automatic ruido(input int unsigned n);
        repeat (n) begin
            bus.Confirma = 1'($urandom_range(0, 1));
            confere("ruido", 1'b0, 1'b0, 1'b0);
            borda();
        end
        solta_confirma("ruido_fim");
    endtask

    task automatic op_reset(input int unsigned atraso);
        bus.In = 1'b1;
        confere("rst_decod", 1'b1, 1'b0, 1'b0);
        borda();
        repeat (atraso) begin
            confere("rst_espera", 1'b1, 1'b0, 1'b0);
            borda();
        end
        reset = 1'b1;
        m_display = '0;
        m_dado = '0;
        m_valido = 1'b0;
        #1;
        verifica("rst_async_display", bus.Display, 32'h0);
        verifica("rst_async_escreve", 32'(bus.EscreveIn), 32'h0);
        confere("rst_ativo", 1'b1, 1'b0, 1'b0);
        bus.In = 1'b0;
        #1;
        verifica("rst_pausa_sem_in", 32'(bus.Pausa), 32'h0);
        borda();
        reset = 1'b0;
        bus.Confirma = 1'b1;
        repeat (BAIXO_MIN) begin
            confere("rst_pos", 1'b0, 1'b0, 1'b0);
            borda();
        end
        solta_confirma("rst_solta");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.In = 1'b0;
        bus.Out = 1'b0;
        bus.Break = 1'b0;
        bus.DadoSaida = '0;
        bus.Chaves = '0;
        bus.Confirma = 1'b0;
        m_display = '0;
        m_dado = '0;
        m_valido = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        confere("reset", 1'b0, 1'b0, 1'b0);
        bus.Break = 1'b1;
        #1;
        verifica("reset_pausa_break", 32'(bus.Pausa), 32'h1);
        bus.Break = 1'b0;
        borda();
        reset = 1'b0;
        confere("ocioso", 1'b0, 1'b0, 1'b0);
        borda();

        op_out(32'hDEADBEEF);
        op_in(16'h00A5, 10, 1'b0, 1'b0);
        op_in(16'h3C5A, 6, 1'b0, 1'b1);
        op_in(16'h1234, 2, 1'b1, 1'b1);
        op_break(3, 1'b1, 1'b1);
        ruido(5);
        op_reset(4);
        op_out(32'h0000_0001);

`ifdef CONTROLE_ES_DEBOUNCE_EN
        bus.In = 1'b1;
        bus.Chaves = 16'hBEEF;
        confere("deb_decod", 1'b1, 1'b0, 1'b0);
        borda();
        bus.Confirma = 1'b1;
        repeat (3) begin
            confere("deb_glitch", 1'b1, 1'b0, 1'b0);
            borda();
        end
        bus.Confirma = 1'b0;
        repeat (10) begin
            confere("deb_glitch_pos", 1'b1, 1'b0, 1'b0);
            borda();
        end
        bus.In = 1'b0;
        op_in(16'hBEEF, 0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: op_out($urandom);
                1: op_in(16'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                2: op_break($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: ruido($urandom_range(1, 6));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_entrada_saida.md
# controle_entrada_saida

I/O responder for the processor's In, Out and Break control signals, sitting between the control unit/datapath and the board's switches, confirm button and display. It stalls the datapath during an In instruction until the operator confirms, then delivers the switch value for one register-write cycle. It captures the Out value into a display register. On Break it halts the processor until the operator resumes.

## Interface
Parameters:
- LARGURA_CHAVES, 16, width of the switch input; zero-extended to 32 bits.
- CICLOS_DEBOUNCE, 16'd50000, stable cycles required on Confirma; used only with debounce compiled in.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces all state to reset values
- In  in  1  control unit: current instruction is In
- Out  in  1  control unit: current instruction is Out
- Break  in  1  control unit: current instruction is Break
- DadoSaida  in  32  register value to display (valid when Out=1)
- Chaves  in  LARGURA_CHAVES  raw switch value, asynchronous
- Confirma  in  1  raw confirm button, active-high, asynchronous
- Pausa  out  1  hold PC and suppress all state writes this cycle
- EscreveIn  out  1  one-cycle pulse: write DadoEntrada to destination register
- DadoEntrada  out  32  {zeros, captured Chaves}
- Display  out  32  last Out value
- DisplayValido  out  1  set by first Out, cleared only by reset
- Parado  out  1  processor halted by Break

## Operation
- Confirma path: two-flop synchronizer, then (optional) debounce filter, then edge detector on the filtered level. conf_pulso = filtered & ~filtered_prev. Chaves is sampled only at capture. Switches are static by usage, so Chaves has no synchronizer.
- FSM states: OCIOSO, ESPERA_ENTRADA, ENTREGA, PARADO, RETOMA. Reset state is OCIOSO.
- OCIOSO: the priority order is Break > In > Out.
  - Break=1 -> PARADO.
  - In=1 -> ESPERA_ENTRADA.
  - Out=1 (In=Break=0) -> Display<=DadoSaida and DisplayValido<=1; the state stays OCIOSO.
- ESPERA_ENTRADA: on conf_pulso=1, DadoEntrada<={zeros,Chaves} and the state goes to ENTREGA. Otherwise it stays.
- ENTREGA: EscreveIn=1 and Pausa=0. In, Out and Break are ignored. Next state is OCIOSO.
- PARADO: Parado=1. On conf_pulso=1 the state goes to RETOMA.
- RETOMA: Pausa=0 and Parado=0. Break, In and Out are ignored. Next state is OCIOSO. This lets the PC step past the Break.
- Pausa is combinational: (OCIOSO & (In|Break)) | ESPERA_ENTRADA | PARADO. It is 0 in ENTREGA, RETOMA, and OCIOSO when In=Break=0.
- A Confirma edge outside ESPERA_ENTRADA or PARADO is discarded. A held button never produces a second pulse without first releasing.
- Simultaneous events:
  - In and Out both set in OCIOSO: only In is acted on, and Display is unchanged.
  - conf_pulso in the same cycle as the entry into ESPERA_ENTRADA: discarded, because it is sampled only while in the state.

## Timing
- Reset values:
  - state OCIOSO
  - Pausa = In|Break (combinational)
  - EscreveIn 0
  - DadoEntrada 0
  - Display 0
  - DisplayValido 0
  - Parado 0
  - synchronizer, filter and edge registers 0
- Asserting reset mid-wait aborts the In or Break immediately. There is no pending write after release.
- In handling:
  - In decoded in cycle n: Pausa=1 in cycle n, and the state is ESPERA_ENTRADA from n+1.
  - Confirma rising before edge k, without debounce: conf_pulso during the cycle after edge k+1. The state is ENTREGA after edge k+2, and EscreveIn is high for exactly that one cycle.
  - With debounce, add CICLOS_DEBOUNCE cycles.
- Out: Display updates at the rising edge that ends the Out cycle. Zero-stall.
- Break: Parado rises one cycle after Break is decoded. After conf_pulso there is exactly one RETOMA cycle with Pausa=0.

## Configuration
- CONTROLE_ES_DEBOUNCE_EN defined: the filter output changes only after the synchronized Confirma has differed from it for CICLOS_DEBOUNCE consecutive cycles. The counter clears on any agreement.
- Not defined: the filter is a wire and CICLOS_DEBOUNCE is unused. Use this for simulation.

## Test plan
- Out: Out=1 with DadoSaida=32'hDEADBEEF -> next cycle Display=32'hDEADBEEF, DisplayValido=1, Pausa=0 throughout.
- In: In=1, Chaves=16'h00A5, then Confirma pulse after 10 cycles -> Pausa high until ENTREGA, then a single EscreveIn cycle with DadoEntrada=32'h000000A5 and Pausa=0.
- Held button: Confirma held high across two consecutive In instructions -> the first completes; the second waits until Confirma falls and rises again.
- Break: Break=1 -> Parado=1 and Pausa=1. A Confirma pulse then gives one RETOMA cycle with Pausa=0 and Break=1 ignored, then OCIOSO.
- Reset mid-wait: reset asserted in ESPERA_ENTRADA -> state OCIOSO, EscreveIn never pulses, all outputs at reset values.
- Debounce (macro on, CICLOS_DEBOUNCE=4): a 3-cycle glitch on Confirma produces no capture; 5 stable cycles produce exactly one capture.
